vram_cpu_port: RTL

- Host-side initiator for the 32K x 8 single-port VRAM. The RAM has a 1-cycle registered read, `dout` is valid on the edge after `addr` is presented, and `we=1` writes.
- Decodes TMS9918/V9958-style CPU accesses on the data and control ports: two-byte address/register setup, read-ahead buffer, auto-increment.
- Sits between the host bus synchroniser and the VRAM; it is the CPU's only path to video memory.

---
 rtl/vdp_pkg.sv | 17 +
 rtl/vram_cpu_port.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP host-side VRAM port.
// State encoding and control-port decode values.
package vdp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_CAPTURE,
        ST_WR_ISSUE
    } state_t;

    localparam logic [1:0] CTL_RD_SETUP = 2'b00;
    localparam logic [1:0] CTL_WR_SETUP = 2'b01;
    localparam int         CTL_REG_WR   = 7;
    localparam logic [5:0] REG_ADDR_HI  = 6'd14;

endpackage

// File: rtl/vram_cpu_port.sv
// CPU data/control port decoder and VRAM initiator (read-ahead, auto-increment).
// Optional dropped-request counter: define VRAM_PORT_DROPCNT_EN.
module vram_cpu_port
    import vdp_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic              cpu_mode,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_busy,
    input  logic [7:0]        status_in,
    output logic              status_rd,
    output logic              reg_we,
    output logic [5:0]        reg_num,
    output logic [7:0]        reg_val,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
`ifdef VRAM_PORT_DROPCNT_EN
    ,
    output logic [DROP_W-1:0] drop_cnt
`endif
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_rdbuf;
    logic [7:0]        r_wbuf;
    logic              r_flag;
    logic [7:0]        r_lat;
    logic [7:0]        r_cpu_dout;
    logic              r_status_rd;
    logic              r_reg_we;
    logic [5:0]        r_reg_num;
    logic [7:0]        r_reg_val;

    assign cpu_dout  = r_cpu_dout;
    assign cpu_busy  = (r_state != ST_IDLE);
    assign status_rd = r_status_rd;
    assign reg_we    = r_reg_we;
    assign reg_num   = r_reg_num;
    assign reg_val   = r_reg_val;
    assign ram_addr  = r_addr;
    assign ram_din   = r_wbuf;
    // Gate with rst_n so a reset edge during WR_ISSUE never writes
    assign ram_we    = (r_state == ST_WR_ISSUE) & rst_n;

    // Access FSM with address, read-ahead buffer and first-byte latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_rdbuf     <= '0;
            r_wbuf      <= '0;
            r_flag      <= 1'b0;
            r_lat       <= '0;
            r_cpu_dout  <= '0;
            r_status_rd <= 1'b0;
            r_reg_we    <= 1'b0;
            r_reg_num   <= '0;
            r_reg_val   <= '0;
        end else begin
            r_status_rd <= 1'b0;
            r_reg_we    <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        if (!cpu_mode) begin
                            r_flag <= 1'b0;
                            if (cpu_wr) begin
                                r_wbuf  <= cpu_din;
                                r_rdbuf <= cpu_din;
                                r_state <= ST_WR_ISSUE;
                            end else begin
                                r_cpu_dout <= r_rdbuf;
                                r_state    <= ST_RD_ISSUE;
                            end
                        end else if (!cpu_wr) begin
                            r_cpu_dout  <= status_in;
                            r_status_rd <= 1'b1;
                            r_flag      <= 1'b0;
                        end else if (!r_flag) begin
                            r_lat  <= cpu_din;
                            r_flag <= 1'b1;
                        end else begin
                            r_flag <= 1'b0;
                            case (cpu_din[7:6])
                                CTL_RD_SETUP: begin
                                    r_addr[13:0] <= {cpu_din[5:0], r_lat};
                                    r_state      <= ST_RD_ISSUE;
                                end
                                CTL_WR_SETUP: begin
                                    r_addr[13:0] <= {cpu_din[5:0], r_lat};
                                end
                                default: begin
                                    r_reg_we  <= cpu_din[CTL_REG_WR];
                                    r_reg_num <= cpu_din[5:0];
                                    r_reg_val <= r_lat;
                                    if (cpu_din[5:0] == REG_ADDR_HI)
                                        r_addr[ADDR_W-1:14] <= r_lat[ADDR_W-15:0];
                                end
                            endcase
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    r_state <= ST_RD_CAPTURE;
                end
                ST_RD_CAPTURE: begin
                    r_rdbuf <= ram_dout;
                    r_addr  <= r_addr + 1'b1;
                    r_state <= ST_IDLE;
                end
                ST_WR_ISSUE: begin
                    r_addr  <= r_addr + 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef VRAM_PORT_DROPCNT_EN
    logic [DROP_W-1:0] r_drop_cnt;

    assign drop_cnt = r_drop_cnt;

    // Saturating count of requests that arrive while busy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (cpu_req && cpu_busy && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end
`endif

endmodule
